// File: rtl/game_pkg.sv
// Shared types and constants for the Doodle Jump game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        PAUSE = 3'd2,
        DYING = 3'd3,
        OVER  = 3'd4
    } game_state_t;

    localparam int LIVES_W          = 4;
    localparam int SCREEN_H_DEFAULT = 600;

endpackage

// File: rtl/frame_ticker.sv
// Per-frame update pulse, taken either from a clock divider or from the
// falling edge of the active-low VGA vertical sync.
module frame_ticker #(
    parameter int CLK      = 50000000,
    parameter int FPS      = 50,
    parameter int TICK_SRC = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic frame_tick
);

    localparam int DIV   = (CLK / FPS < 1) ? 1 : CLK / FPS;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             vsync_q;
    logic             vsync_qq;
    logic             tick_next;

    // The divider pulse is registered, so it is raised for the cycle in which
    // the counter sits at its last value.
    always_comb begin
        cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (TICK_SRC == 1) begin
            tick_next = vsync_qq & ~vsync_q;
        end else begin
            tick_next = (cnt_next == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            vsync_q    <= 1'b0;
            vsync_qq   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= (TICK_SRC == 1) ? '0 : cnt_next;
            vsync_q    <= vsync;
            vsync_qq   <= vsync_q;
            frame_tick <= tick_next;
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Central game sequencer: frame tick, game-state machine, lives, score and
// high score for the Doodle Jump VGA design.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int CLK          = 50000000,
    parameter int FPS          = 50,
    parameter int TICK_SRC     = 0,
    parameter int LIVES        = 3,
    parameter int SCORE_W      = 20,
    parameter int DEATH_FRAMES = 25,
    parameter int SCREEN_H     = SCREEN_H_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               button_left,
    input  logic               button_right,
    input  logic [9:0]         doodle_y,
    input  logic [9:0]         scroll_delta,
    input  logic               scroll_valid,
    output logic               frame_tick,
    output game_state_t        game_state,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               world_freeze,
    output logic               respawn
);

    localparam int DEATH_W = (DEATH_FRAMES > 0) ? $clog2(DEATH_FRAMES + 1) : 1;
    localparam int SUM_W   = ((SCORE_W > 10) ? SCORE_W : 10) + 1;
    localparam logic [SUM_W-1:0] SCORE_MAX  = {{(SUM_W - SCORE_W){1'b0}}, {SCORE_W{1'b1}}};
    localparam logic [9:0]       FALL_LIMIT = 10'(SCREEN_H);

    game_state_t        state_next;
    logic [LIVES_W-1:0] lives_next;
    logic [SCORE_W-1:0] score_next;
    logic [SCORE_W-1:0] high_next;
    logic               respawn_next;
    logic [DEATH_W-1:0] death_cnt;
    logic [DEATH_W-1:0] death_next;
    logic               combo_q;
    logic               combo_edge;
    logic [SUM_W-1:0]   score_sum;

    frame_ticker #(
        .CLK      (CLK),
        .FPS      (FPS),
        .TICK_SRC (TICK_SRC)
    ) u_ticker (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    assign combo_edge   = button_left & button_right & ~combo_q;
    assign score_sum    = SUM_W'(score) + SUM_W'(scroll_delta);
    assign world_freeze = (game_state != PLAY);

    always_comb begin
        state_next   = game_state;
        lives_next   = lives;
        score_next   = score;
        high_next    = high_score;
        respawn_next = 1'b0;
        death_next   = death_cnt;

        case (game_state)
            IDLE: begin
                if (combo_edge) begin
                    lives_next   = LIVES_W'(LIVES);
                    score_next   = '0;
                    respawn_next = 1'b1;
                    state_next   = PLAY;
                end
            end
            PLAY: begin
                if (scroll_valid) begin
                    score_next = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}}
                                                         : score_sum[SCORE_W-1:0];
                end
                // A fall wins over a pause request arriving in the same cycle.
                if (doodle_y > FALL_LIMIT) begin
                    death_next = DEATH_W'(DEATH_FRAMES);
                    state_next = DYING;
                end else if (combo_edge) begin
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (combo_edge) begin
                    state_next = PLAY;
                end
            end
            DYING: begin
                if (death_cnt == '0) begin
                    if (lives > LIVES_W'(1)) begin
                        lives_next   = lives - 1'b1;
                        respawn_next = 1'b1;
                        state_next   = PLAY;
                    end else begin
                        lives_next = '0;
                        if (score > high_score) begin
                            high_next = score;
                        end
                        state_next = OVER;
                    end
                end else if (frame_tick) begin
                    death_next = death_cnt - 1'b1;
                end
            end
            OVER: begin
                if (combo_edge) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            game_state <= IDLE;
            lives      <= '0;
            score      <= '0;
            high_score <= '0;
            respawn    <= 1'b0;
            death_cnt  <= '0;
            combo_q    <= 1'b0;
        end else begin
            game_state <= state_next;
            lives      <= lives_next;
            score      <= score_next;
            high_score <= high_next;
            respawn    <= respawn_next;
            death_cnt  <= death_next;
            combo_q    <= button_left & button_right;
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench: divider DUT (3 lives, 20-bit score) and vsync DUT
// (1 life, 8-bit score, 2 death frames).
module tb_game_flow_controller;
    import game_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        rst_a, vsync_a, bl_a, br_a, valid_a;
    logic [9:0]  doodle_a, delta_a;
    logic        tick_a, freeze_a, respawn_a;
    game_state_t state_a;
    logic [3:0]  lives_a;
    logic [19:0] score_a, high_a;

    logic        rst_b, vsync_b, bl_b, br_b, valid_b;
    logic [9:0]  doodle_b, delta_b;
    logic        tick_b, freeze_b, respawn_b;
    game_state_t state_b;
    logic [3:0]  lives_b;
    logic [7:0]  score_b, high_b;

    game_flow_controller #(
        .CLK(1000), .FPS(10), .TICK_SRC(0), .LIVES(3),
        .SCORE_W(20), .DEATH_FRAMES(25), .SCREEN_H(600)
    ) dut_a (
        .clk(clk), .rst(rst_a), .vsync(vsync_a),
        .button_left(bl_a), .button_right(br_a),
        .doodle_y(doodle_a), .scroll_delta(delta_a), .scroll_valid(valid_a),
        .frame_tick(tick_a), .game_state(state_a), .lives(lives_a),
        .score(score_a), .high_score(high_a),
        .world_freeze(freeze_a), .respawn(respawn_a)
    );

    game_flow_controller #(
        .CLK(1000), .FPS(10), .TICK_SRC(1), .LIVES(1),
        .SCORE_W(8), .DEATH_FRAMES(2), .SCREEN_H(600)
    ) dut_b (
        .clk(clk), .rst(rst_b), .vsync(vsync_b),
        .button_left(bl_b), .button_right(br_b),
        .doodle_y(doodle_b), .scroll_delta(delta_b), .scroll_valid(valid_b),
        .frame_tick(tick_b), .game_state(state_b), .lives(lives_b),
        .score(score_b), .high_score(high_b),
        .world_freeze(freeze_b), .respawn(respawn_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string who, input logic [2:0] st, input logic [3:0] lv,
                               input logic [31:0] sc, input logic [31:0] hi,
                               input logic tk, input logic rs, input logic fz);
        check({who, "_state"},  32'(st), 32'(IDLE));
        check({who, "_lives"},  32'(lv), 32'd0);
        check({who, "_score"},  sc, 32'd0);
        check({who, "_high"},   hi, 32'd0);
        check({who, "_tick"},   32'(tk), 32'd0);
        check({who, "_respawn"}, 32'(rs), 32'd0);
        check({who, "_freeze"}, 32'(fz), 32'd1);
    endtask

    initial begin
        int  pulses;
        int  leaves;
        int  dticks;
        int  since;
        bit  exited;

        rst_a = 1'b1; vsync_a = 1'b1; bl_a = 1'b0; br_a = 1'b0;
        valid_a = 1'b0; doodle_a = 10'd300; delta_a = 10'd0;
        rst_b = 1'b1; vsync_b = 1'b1; bl_b = 1'b0; br_b = 1'b0;
        valid_b = 1'b0; doodle_b = 10'd300; delta_b = 10'd0;
        repeat (3) @(negedge clk);

        check_reset("a_reset", state_a, lives_a, 32'(score_a), 32'(high_a), tick_a, respawn_a, freeze_a);
        check_reset("b_reset", state_b, lives_b, 32'(score_b), 32'(high_b), tick_b, respawn_b, freeze_b);

        // Divider ticks: cycle 0 is the one right after the last reset edge.
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int c = 0; c <= 320; c++) begin
            check("a_tick_cycle", 32'(tick_a), 32'(c % 100 == 99));
            @(negedge clk);
        end

        // Held combo starts exactly one game.
        bl_a = 1'b1; br_a = 1'b1;
        @(negedge clk);
        check("a_start_state",   32'(state_a), 32'(PLAY));
        check("a_start_lives",   32'(lives_a), 32'd3);
        check("a_start_score",   32'(score_a), 32'd0);
        check("a_start_respawn", 32'(respawn_a), 32'd1);
        check("a_start_freeze",  32'(freeze_a), 32'd0);
        pulses = 0;
        leaves = 0;
        repeat (299) begin
            @(negedge clk);
            if (respawn_a) pulses++;
            if (state_a != PLAY) leaves++;
        end
        check("a_hold_respawn", 32'(pulses), 32'd0);
        check("a_hold_state",   32'(leaves), 32'd0);

        bl_a = 1'b0; br_a = 1'b0;
        @(negedge clk);
        bl_a = 1'b1; br_a = 1'b1;
        @(negedge clk);
        check("a_pause_state",  32'(state_a), 32'(PAUSE));
        check("a_pause_freeze", 32'(freeze_a), 32'd1);
        bl_a = 1'b0; br_a = 1'b0;
        @(negedge clk);
        valid_a = 1'b1; delta_a = 10'd40;
        @(negedge clk);
        valid_a = 1'b0;
        check("a_pause_score", 32'(score_a), 32'd0);
        bl_a = 1'b1; br_a = 1'b1;
        @(negedge clk);
        check("a_resume_state", 32'(state_a), 32'(PLAY));
        bl_a = 1'b0; br_a = 1'b0;

        valid_a = 1'b1; delta_a = 10'd40;
        repeat (3) @(negedge clk);
        valid_a = 1'b0;
        check("a_score_120", 32'(score_a), 32'd120);

        // Fall with a same-cycle combo edge and score update.
        doodle_a = 10'd601; bl_a = 1'b1; br_a = 1'b1;
        valid_a = 1'b1; delta_a = 10'd5;
        @(negedge clk);
        check("a_fall_state",  32'(state_a), 32'(DYING));
        check("a_fall_score",  32'(score_a), 32'd125);
        check("a_fall_freeze", 32'(freeze_a), 32'd1);
        dticks = 0;
        if (state_a == DYING && tick_a) dticks++;
        doodle_a = 10'd300; valid_a = 1'b0; bl_a = 1'b0; br_a = 1'b0;
        @(negedge clk);
        if (state_a == DYING && tick_a) dticks++;
        bl_a = 1'b1; br_a = 1'b1;
        @(negedge clk);
        if (state_a == DYING && tick_a) dticks++;
        check("a_dying_combo_ignored", 32'(state_a), 32'(DYING));
        bl_a = 1'b0; br_a = 1'b0;

        since  = 0;
        exited = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (state_a != DYING) begin
                exited = 1'b1;
                break;
            end
            if (tick_a) begin
                dticks++;
                since = 0;
            end else begin
                since++;
            end
        end
        check("a_dying_exit_timeout", 32'(exited), 32'd1);
        check("a_dying_ticks",   32'(dticks), 32'd25);
        check("a_dying_tail",    32'(since), 32'd1);
        check("a_respawn_state", 32'(state_a), 32'(PLAY));
        check("a_respawn_lives", 32'(lives_a), 32'd2);
        check("a_respawn_pulse", 32'(respawn_a), 32'd1);
        check("a_respawn_score", 32'(score_a), 32'd125);
        @(negedge clk);
        check("a_respawn_single", 32'(respawn_a), 32'd0);

        // Vsync-driven ticks: low for 2 cycles every 500 cycles.
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 500; k++) begin
                check("b_vsync_tick", 32'(tick_b), 32'(k == 2));
                vsync_b = (k < 2) ? 1'b0 : 1'b1;
                @(negedge clk);
            end
        end

        bl_b = 1'b1; br_b = 1'b1;
        @(negedge clk);
        check("b_start_state",   32'(state_b), 32'(PLAY));
        check("b_start_lives",   32'(lives_b), 32'd1);
        check("b_start_respawn", 32'(respawn_b), 32'd1);
        bl_b = 1'b0; br_b = 1'b0;
        valid_b = 1'b1; delta_b = 10'd250;
        @(negedge clk);
        check("b_score_250", 32'(score_b), 32'd250);
        delta_b = 10'd40;
        @(negedge clk);
        valid_b = 1'b0;
        check("b_score_sat", 32'(score_b), 32'd255);

        doodle_b = 10'd700;
        @(negedge clk);
        check("b_fall_state", 32'(state_b), 32'(DYING));
        doodle_b = 10'd300;
        exited = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (state_b != DYING) begin
                exited = 1'b1;
                break;
            end
            vsync_b = (i % 20 < 2) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        vsync_b = 1'b1;
        check("b_dying_exit_timeout", 32'(exited), 32'd1);
        check("b_over_state",   32'(state_b), 32'(OVER));
        check("b_over_lives",   32'(lives_b), 32'd0);
        check("b_over_high",    32'(high_b), 32'd255);
        check("b_over_respawn", 32'(respawn_b), 32'd0);
        check("b_over_freeze",  32'(freeze_b), 32'd1);

        bl_b = 1'b1; br_b = 1'b1;
        @(negedge clk);
        check("b_idle_state", 32'(state_b), 32'(IDLE));
        check("b_idle_score", 32'(score_b), 32'd255);
        bl_b = 1'b0; br_b = 1'b0;
        @(negedge clk);
        bl_b = 1'b1; br_b = 1'b1;
        @(negedge clk);
        check("b_restart_state", 32'(state_b), 32'(PLAY));
        check("b_restart_score", 32'(score_b), 32'd0);
        check("b_restart_high",  32'(high_b), 32'd255);
        bl_b = 1'b0; br_b = 1'b0;

        // Reset in the middle of a game discards everything.
        rst_b = 1'b1;
        @(negedge clk);
        check_reset("b_midreset", state_b, lives_b, 32'(score_b), 32'(high_b), tick_b, respawn_b, freeze_b);
        rst_b = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
